aer_event_receiver: RTL

Consumes the arbitrated address-event stream from pixel_level: x/y address, active strobe, pixel polarity and group-release. Each event is tagged with a free-running timestamp and packed into a fixed-width word. Words are buffered in a FIFO and presented on a valid/ready stream to the readout path. The block also drives pixel_level's enable_i as backpressure, so the arbiter is throttled before the FIFO fills.

---
 rtl/aer_evt_pkg.sv | 36 +++
 rtl/evt_fifo.sv | 56 +++++
 rtl/aer_event_receiver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/aer_evt_pkg.sv
// Shared types and default widths for the AER event receiver.
// Packed word layout, MSB first: {grp_end, pol, x, y, ts}.
package aer_evt_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int POL_W_DEF  = 2;
  localparam int TS_W_DEF   = 16;
  localparam int PKT_W      = 1 + POL_W_DEF + 2 * ADDR_W_DEF + TS_W_DEF;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_THROTTLE = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    RUN      = ST_RUN,
    THROTTLE = ST_THROTTLE
  } rx_state_t;

  typedef struct packed {
    logic                  grp_end;
    logic [POL_W_DEF-1:0]  pol;
    logic [ADDR_W_DEF-1:0] x;
    logic [ADDR_W_DEF-1:0] y;
    logic [TS_W_DEF-1:0]   ts;
  } evt_pkt_t;

  function automatic evt_pkt_t make_marker(input logic [TS_W_DEF-1:0] ts);
    evt_pkt_t pkt;
    pkt         = '0;
    pkt.grp_end = 1'b1;
    pkt.ts      = ts;
    return pkt;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through FIFO: the head word is visible on pop_data_o while not empty.
// A push into a full FIFO is accepted only if a pop frees a slot in the same cycle.
module evt_fifo #(
  parameter  int WIDTH = 23,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_reg == '0);
  assign full_o     = (count_reg == CW'(DEPTH));
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign overflow_o = push_i & full_o & ~do_pop;
  assign count_o    = count_reg;
  // Empty reads return zero so the data output is defined straight out of reset.
  assign pop_data_o = empty_o ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/aer_event_receiver.sv
// Timestamps arbiter events into packed words, buffers them and throttles the arbiter.
// Optional macro AER_DROP_CNT_EN adds a saturating dropped-word counter (drop_cnt_o).
module aer_event_receiver
  import aer_evt_pkg::*;
#(
  parameter  int ADDR_W       = ADDR_W_DEF,
  parameter  int POL_W        = POL_W_DEF,
  parameter  int TS_W         = TS_W_DEF,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int AFULL_MARGIN = 2,
  localparam int WORD_W       = 1 + POL_W + 2 * ADDR_W + TS_W,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              active_i,
  input  logic [ADDR_W-1:0] x_add_i,
  input  logic [ADDR_W-1:0] y_add_i,
  input  logic [POL_W-1:0]  polarity_i,
  input  logic              grp_release_i,
  output logic              arb_enable_o,
  output logic [WORD_W-1:0] event_data_o,
  output logic              event_valid_o,
  input  logic              event_ready_i,
  output logic [CNT_W-1:0]  fifo_count_o,
  output logic              overflow_o
`ifdef AER_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] HI_MARK = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [CNT_W-1:0] LO_MARK = CNT_W'(FIFO_DEPTH / 2);

  logic [TS_W-1:0]   ts_reg;
  rx_state_t         state_reg;
  rx_state_t         state_next;
  logic              arb_enable_reg;
  logic              overflow_reg;
  logic              push;
  logic [WORD_W-1:0] push_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_ovf;
  logic [CNT_W-1:0]  count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       ts_reg <= '0;
    else if (enable_i) ts_reg <= ts_reg + TS_W'(1);
  end

  // A release without a grant becomes a marker word carrying only grp_end and ts.
  assign push      = active_i | grp_release_i;
  assign push_data = active_i ? {grp_release_i, polarity_i, x_add_i, y_add_i, ts_reg}
                              : {1'b1, {POL_W{1'b0}}, {(2 * ADDR_W){1'b0}}, ts_reg};

  evt_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (event_ready_i),
    .pop_data_o (event_data_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (count),
    .overflow_o (fifo_ovf)
  );

  assign event_valid_o = ~fifo_empty;
  assign fifo_count_o  = count;

  // Hysteresis between HI_MARK and LO_MARK keeps the arbiter from toggling every pop.
  always_comb begin
    state_next = state_reg;
    if (!enable_i) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:     if (count < HI_MARK)   state_next = RUN;
        RUN:      if (count >= HI_MARK)  state_next = THROTTLE;
        THROTTLE: if (count <= LO_MARK)  state_next = RUN;
        default:                         state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      arb_enable_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      arb_enable_reg <= (state_next == RUN);
      overflow_reg   <= overflow_reg | fifo_ovf;
    end
  end

  assign arb_enable_o = arb_enable_reg;
  assign overflow_o   = overflow_reg;

`ifdef AER_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                              drop_cnt_reg <= '0;
    else if (fifo_ovf && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end

  assign drop_cnt_o = drop_cnt_reg;
`else
  logic unused_full;
  assign unused_full = fifo_full;
`endif

endmodule
